data_memory_ctrl: RTL and testbench

Parametrised byte-addressed, big-endian data memory for the pipeline MEM stage. It supports byte, halfword and word loads and stores, with sign or zero extension on loads. Reads are registered, writes are synchronous, and alignment and range violations are reported. After reset a clear sequencer zeroes the array one word per cycle, and a side debug port reads whole words for the debug unit.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_load_align.sv | 38 +++
 rtl/data_memory_ctrl.sv | 148 ++++++++++++++
 tb/tb_data_memory_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory and its helpers.
// Holds access-size encodings, the clear/ready state type and the word width.
// Imported by data_memory_ctrl and mem_load_align.
package mem_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: picks the addressed byte/half/word out of a big-endian word.
// Combinational, zero latency.
// No handshake; the result follows the inputs.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [1:0]        i_off,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [WORD_W-1:0] o_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Select the lane(s) big-endian style, then right-justify and extend
  always_comb begin
    byte_v = 8'h00;
    case (i_off)
      2'd0:    byte_v = i_word[31:24];
      2'd1:    byte_v = i_word[23:16];
      2'd2:    byte_v = i_word[15:8];
      default: byte_v = i_word[7:0];
    endcase
    // Half offsets are always even, so only bit 1 matters here
    half_v = i_off[1] ? i_word[15:0] : i_word[31:16];

    o_data = '0;
    case (i_size)
      SZ_BYTE: o_data = i_unsigned ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: o_data = i_unsigned ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      SZ_WORD: o_data = i_word;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed big-endian data memory with post-reset clear sequencer and debug read port.
// Loads return one cycle after acceptance; stores commit on the accept edge.
// o_ready is low while clearing; requests then are dropped without any response.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int SIZE      = 16,
  parameter int ADDR_BITS = $clog2(SIZE) + 2,
  parameter int DBG_BITS  = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic                 i_rd_en,
  input  logic                 i_wr_en,
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  input  logic [WORD_W-1:0]    i_data,
  output logic [WORD_W-1:0]    o_data,
  output logic                 o_valid,
  output logic                 o_err,
  output logic                 o_ready,
  input  logic [DBG_BITS-1:0]  i_dbg_addr,
  output logic [WORD_W-1:0]    o_dbg_data
);

  localparam int                   IDX_BITS   = ADDR_BITS - 2;
  localparam logic [ADDR_BITS:0]   ADDR_LIMIT = (ADDR_BITS + 1)'(4 * SIZE);
  localparam logic [DBG_BITS:0]    DBG_LIMIT  = (DBG_BITS + 1)'(SIZE);
  localparam logic [DBG_BITS-1:0]  LAST_PTR   = DBG_BITS'(SIZE - 1);

  logic [WORD_W-1:0] mem_q [SIZE];

  state_t              state_q,   state_d;
  logic [DBG_BITS-1:0] clr_ptr_q, clr_ptr_d;
  logic                ready_q,   ready_d;
  logic                valid_q,   valid_d;
  logic                err_q,     err_d;
  logic [WORD_W-1:0]   data_q,    data_d;

  logic [IDX_BITS-1:0] idx;
  logic                in_range;
  logic                accept;
  logic                bad;
  logic                load_ok;
  logic                store_ok;
  logic [WORD_W-1:0]   rd_word;
  logic [WORD_W-1:0]   st_word;
  logic [WORD_W-1:0]   ld_data;

  assign idx      = i_addr[ADDR_BITS-1:2];
  assign in_range = {1'b0, i_addr} < ADDR_LIMIT;
  assign rd_word  = in_range ? mem_q[idx] : '0;

  // Request screening: any failed check rejects the whole access
  always_comb begin
    accept   = (state_q == ST_READY) && (i_rd_en || i_wr_en);
    bad      = (i_rd_en && i_wr_en)
            || (i_size == 2'b11)
            || !in_range
            || ((i_size == SZ_HALF) && i_addr[0])
            || ((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00));
    load_ok  = accept && !bad && i_rd_en;
    store_ok = accept && !bad && i_wr_en;
  end

  // Store lane merge: lane k lives in bits [31-8k -: 8], untouched lanes keep old data
  always_comb begin
    st_word = rd_word;
    for (int k = 0; k < 4; k++) begin
      case (i_size)
        SZ_BYTE: if (i_addr[1:0] == 2'(k)) st_word[31-8*k -: 8] = i_data[7:0];
        SZ_HALF: if (i_addr[1] == k[1])
                   st_word[31-8*k -: 8] = k[0] ? i_data[7:0] : i_data[15:8];
        SZ_WORD: st_word[31-8*k -: 8] = i_data[31-8*k -: 8];
        default: ;
      endcase
    end
  end

  mem_load_align u_load_align (
    .i_word     (rd_word),
    .i_off      (i_addr[1:0]),
    .i_size     (i_size),
    .i_unsigned (i_unsigned),
    .o_data     (ld_data)
  );

  // Next-state: clear sweep, then single-cycle request responses
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    data_d    = data_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_PTR) begin
          state_d   = ST_READY;
          ready_d   = 1'b1;
          clr_ptr_d = '0;
        end
      end
      default: begin
        valid_d = load_ok;
        err_d   = accept && bad;
        if (load_ok) data_d = ld_data;
      end
    endcase
  end

  // Control and output registers; reset restarts the clear sweep from word 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      data_q    <= data_d;
    end
  end

  // Storage array: clear writes take priority, stores only land in READY
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (store_ok) begin
      mem_q[idx] <= st_word;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_err      = err_q;
  assign o_ready    = ready_q;
  assign o_dbg_data = ({1'b0, i_dbg_addr} < DBG_LIMIT) ? mem_q[i_dbg_addr] : '0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl (SIZE=16 main instance, SIZE=12 for range edge).
// Expectations come from a byte-array reference model pushed at drive time.
// Popped and compared one cycle after each request edge.
module tb_data_memory_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  i_addr = '0;
  logic        i_rd_en = 1'b0, i_wr_en = 1'b0, i_unsigned = 1'b0;
  logic [1:0]  i_size = '0;
  logic [31:0] i_data = '0;
  logic [31:0] o_data, o_dbg_data;
  logic        o_valid, o_err, o_ready;
  logic [3:0]  i_dbg_addr = '0;

  logic [5:0]  a12 = '0;
  logic        rd12 = 1'b0;
  logic [3:0]  dbg12 = '0;
  logic [31:0] o_data12, o_dbg12;
  logic        o_valid12, o_err12, o_ready12;

  always #5 clk = ~clk;

  data_memory_ctrl #(.SIZE(16)) dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_rd_en(i_rd_en), .i_wr_en(i_wr_en),
    .i_size(i_size), .i_unsigned(i_unsigned), .i_data(i_data), .o_data(o_data),
    .o_valid(o_valid), .o_err(o_err), .o_ready(o_ready), .i_dbg_addr(i_dbg_addr),
    .o_dbg_data(o_dbg_data));

  data_memory_ctrl #(.SIZE(12)) dut12 (
    .clk(clk), .rst(rst), .i_addr(a12), .i_rd_en(rd12), .i_wr_en(1'b0),
    .i_size(SZ_WORD), .i_unsigned(1'b0), .i_data(32'h0), .o_data(o_data12),
    .o_valid(o_valid12), .o_err(o_err12), .o_ready(o_ready12), .i_dbg_addr(dbg12),
    .o_dbg_data(o_dbg12));

  typedef struct {
    string       tag;
    logic        v;
    logic        e;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mb [64];
  logic [31:0] last_data;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] m_word(input int w);
    return {mb[4*w], mb[4*w+1], mb[4*w+2], mb[4*w+3]};
  endfunction

  function automatic logic [31:0] m_load(input int a, input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (sz)
      2'd0: begin b = mb[a]; return uns ? {24'h0, b} : {{24{b[7]}}, b}; end
      2'd1: begin h = {mb[a], mb[a+1]}; return uns ? {16'h0, h} : {{16{h[15]}}, h}; end
      default: return {mb[a], mb[a+1], mb[a+2], mb[a+3]};
    endcase
  endfunction

  task automatic m_store(input int a, input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0: mb[a] = d[7:0];
      2'd1: begin mb[a] = d[15:8]; mb[a+1] = d[7:0]; end
      default: begin mb[a] = d[31:24]; mb[a+1] = d[23:16]; mb[a+2] = d[15:8]; mb[a+3] = d[7:0]; end
    endcase
  endtask

  task automatic m_clear();
    for (int i = 0; i < 64; i++) mb[i] = 8'h00;
    last_data = 32'h0;
  endtask

  // Drive one request (or idle), predict the response, then compare after the edge
  task automatic issue(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [5:0] a, input logic uns, input logic [31:0] d);
    exp_t e;
    logic bad;
    exp_t g;
    bad = (rd && wr) || (sz == 2'b11) || ((sz == 2'b01) && a[0]) ||
          ((sz == 2'b10) && (a[1:0] != 2'b00));
    e.tag = tag; e.v = 1'b0; e.e = 1'b0;
    if (rd || wr) begin
      if (bad) e.e = 1'b1;
      else if (wr) m_store(int'(a), sz, d);
      else begin e.v = 1'b1; last_data = m_load(int'(a), sz, uns); end
    end
    e.d = last_data;
    sb.push_back(e);
    i_addr = a; i_rd_en = rd; i_wr_en = wr; i_size = sz; i_unsigned = uns; i_data = d;
    @(posedge clk); #1;
    i_rd_en = 1'b0; i_wr_en = 1'b0;
    g = sb.pop_front();
    chk({g.tag, "_valid"}, {31'h0, o_valid}, {31'h0, g.v});
    chk({g.tag, "_err"},   {31'h0, o_err},   {31'h0, g.e});
    chk({g.tag, "_data"},  o_data, g.d);
  endtask

  task automatic dbg_chk(input string tag, input logic [3:0] w);
    i_dbg_addr = w; #1;
    chk(tag, o_dbg_data, m_word(int'(w)));
  endtask

  // Release reset and count cycles until o_ready, holding a bad read to prove it is ignored
  task automatic release_and_wait(input string tag);
    int  c;
    logic seen;
    c = 0; seen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    i_rd_en = 1'b1; i_addr = 6'h3F; i_size = SZ_WORD;
    while (!o_ready && c < 100) begin
      @(posedge clk); #1;
      c++;
      if (o_valid || o_err) seen = 1'b1;
    end
    i_rd_en = 1'b0;
    chk({tag, "_ready_cycles"}, c, 16);
    chk({tag, "_silent"}, {31'h0, seen}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sz;
    logic [5:0] a;
    int         op;
    m_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data",  o_data, 32'h0);
    chk("rst_valid", {31'h0, o_valid}, 32'h0);
    chk("rst_err",   {31'h0, o_err},   32'h0);
    chk("rst_ready", {31'h0, o_ready}, 32'h0);

    // 1. clear and ready
    release_and_wait("t1");
    chk("t1_ready12", {31'h0, o_ready12}, 32'h1);
    issue("t1_ld3c", 1, 0, SZ_WORD, 6'h3C, 0, 0);

    // 2. word store and narrow loads
    issue("t2_st08", 0, 1, SZ_WORD, 6'h08, 0, 32'h11223344);
    issue("t2_lb09", 1, 0, SZ_BYTE, 6'h09, 1, 0);
    chk("t2_lb09_lit", o_data, 32'h00000022);
    issue("t2_lh0a", 1, 0, SZ_HALF, 6'h0A, 0, 0);
    chk("t2_lh0a_lit", o_data, 32'h00003344);
    issue("t2_lw08", 1, 0, SZ_WORD, 6'h08, 0, 0);
    dbg_chk("t2_dbg2", 4'd2);
    chk("t2_dbg2_lit", o_dbg_data, 32'h11223344);

    // 3. sign extension
    issue("t3_sb0d", 0, 1, SZ_BYTE, 6'h0D, 0, 32'h00000085);
    issue("t3_lbs",  1, 0, SZ_BYTE, 6'h0D, 0, 0);
    chk("t3_lbs_lit", o_data, 32'hFFFFFF85);
    issue("t3_lbu",  1, 0, SZ_BYTE, 6'h0D, 1, 0);
    issue("t3_lw0c", 1, 0, SZ_WORD, 6'h0C, 1, 0);
    chk("t3_lw0c_lit", o_data, 32'h00850000);

    // 4. rejected requests
    issue("t4_sw06", 0, 1, SZ_WORD, 6'h06, 0, 32'hAAAAAAAA);
    dbg_chk("t4_dbg1", 4'd1);
    issue("t4_lh03", 1, 0, SZ_HALF, 6'h03, 0, 0);
    issue("t4_sz11", 1, 0, 2'b11,   6'h00, 0, 0);
    issue("t4_rdwr", 1, 1, SZ_WORD, 6'h08, 0, 32'h55555555);
    dbg_chk("t4_dbg2", 4'd2);
    a12 = 6'h2C; rd12 = 1'b1;
    @(posedge clk); #1;
    chk("t4_12_ok_valid", {31'h0, o_valid12}, 32'h1);
    a12 = 6'h30;
    @(posedge clk); #1;
    rd12 = 1'b0;
    chk("t4_12_range_err",   {31'h0, o_err12},   32'h1);
    chk("t4_12_range_valid", {31'h0, o_valid12}, 32'h0);
    chk("t4_12_range_data",  o_data12, 32'h0);
    dbg12 = 4'd13; #1;
    chk("t4_12_dbg_oob", o_dbg12, 32'h0);

    // 5. store then load on the next edge
    issue("t5_sh10", 0, 1, SZ_HALF, 6'h10, 0, 32'h0000BEEF);
    issue("t5_lh10", 1, 0, SZ_HALF, 6'h10, 1, 0);
    chk("t5_lh10_lit", o_data, 32'h0000BEEF);
    issue("t5_idle", 0, 0, SZ_WORD, 6'h10, 0, 0);

    // random mix against the byte model
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 2));
      a  = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SZ_HALF) a[0] = 1'b0;
        if (sz == SZ_WORD) a[1:0] = 2'b00;
      end
      op = $urandom_range(0, 7);
      issue("rnd", op < 3, (op >= 3 && op < 6) || op == 7, sz, a, 1'($urandom_range(0, 1)),
            $urandom);
    end

    // 6. reset mid-clear
    issue("t6_sw14", 0, 1, SZ_WORD, 6'h14, 0, 32'hDEADBEEF);
    issue("t6_sw30", 0, 1, SZ_WORD, 6'h30, 0, 32'hCAFEF00D);
    dbg_chk("t6_dbg5", 4'd5);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("t6_rst_ready", {31'h0, o_ready}, 32'h0);
    chk("t6_rst_data",  o_data, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    i_dbg_addr = 4'd5; #1;
    chk("t6_mid_dbg5", o_dbg_data, 32'h0);
    i_dbg_addr = 4'd12; #1;
    chk("t6_mid_dbg12", o_dbg_data, 32'hCAFEF00D);
    chk("t6_mid_ready", {31'h0, o_ready}, 32'h0);
    rst = 1'b0;
    m_clear();
    #2;
    release_and_wait("t6");
    issue("t6_lw14", 1, 0, SZ_WORD, 6'h14, 0, 0);
    chk("t6_lw14_lit", o_data, 32'h0);
    dbg_chk("t6_dbg12", 4'd12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
